ps2_key_sequencer: RTL and testbench
====================================

Name: ps2_key_sequencer

Overview:
- Controller between the PS/2 receive FIFO (ps2_keyboard) and the display/counter logic.
- Pops scan-code bytes using the FIFO's ready/nextdata_n handshake and folds E0/F0/E1 prefixes into single key events.
- Tracks shift/ctrl/caps modifier state, suppresses typematic repeats in the press counter, and recovers from stale prefixes and FIFO overflow.

Parameters:
TIMEOUT_CYC, 1000000, cycles a pending prefix may wait for its follow-up byte before being discarded
CNT_W, 8, width of press_count

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
in_data  in  8  FIFO head byte; valid while in_ready=1
in_ready  in  1  FIFO non-empty
overflow  in  1  FIFO overflow flag, level
nextdata_n  out  1  active-low pop strobe to FIFO, one cycle per byte
key_valid  out  1  one-cycle pulse: key event on key_code/key_ext/key_break
key_code  out  8  final scan code of event
key_ext  out  1  event carried E0 prefix
key_break  out  1  event is a release (F0 prefix)
key_repeat  out  1  event is a typematic repeat make
shift  out  1  left (12) or right (59) shift held
ctrl  out  1  left (14) or right (E0 14) ctrl held
caps  out  1  caps-lock toggle state
press_count  out  CNT_W  count of non-repeat make events, wraps
err  out  1  sticky; set on overflow, cleared only by reset

Behaviour:
- Reset (async) values: nextdata_n=1; key_valid=0; key_code=0; key_ext=0; key_break=0; key_repeat=0; shift=0; ctrl=0; caps=0; press_count=0; err=0. State=IDLE. Pending flags, last_make, E1 skip count and timer are cleared.
- FSM states: IDLE, POP, SETTLE, DECODE.
- IDLE: if in_ready=1, latch in_data into byte_r and go to POP.
- POP: drive nextdata_n=0 for exactly this cycle, then go to SETTLE.
- SETTLE: one idle cycle so that in_ready reflects the advanced FIFO, then go to DECODE.
- DECODE: process byte_r and return to IDLE. Byte throughput is at most one per 4 cycles. nextdata_n is never low in two consecutive cycles.
- Decode rules, in priority order:
  - skip_cnt>0: decrement and discard the byte.
  - byte=E1: skip_cnt=7 and discard (Pause sequence). No event is emitted.
  - byte=E0: ext_pend=1.
  - byte=F0: brk_pend=1.
  - Any other byte: emit the event, then clear ext_pend and brk_pend.
- Event emission: key_valid=1 in the cycle after DECODE, with key_code=byte_r, key_ext=ext_pend, key_break=brk_pend. Outputs hold their values until the next event; key_valid is a pulse only.
- Make events (key_break=0):
  - key_repeat=1 iff {ext,code} equals last_make. Otherwise key_repeat=0, last_make is set to {ext,code}, and press_count increments (wrapping at 2^CNT_W−1 → 0).
- Break events: key_repeat=0. If {ext,code} equals last_make, last_make is cleared to invalid.
- Modifiers (the 1-bit shift/ctrl outputs are ORs of internal per-side held bits, updated in the same cycle as key_valid):
  - Left shift = non-ext 12; right shift = non-ext 59.
  - Left ctrl = non-ext 14; right ctrl = ext 14.
  - A make sets the held bit; a break clears it.
  - Fake-shift sequences E0 12 / E0 59 do not affect shift.
- Caps (code 58, non-ext): toggles on a non-repeat make only. Breaks and repeats leave it unchanged.
- Timeout: the timer runs while ext_pend or brk_pend is set and no byte is available. At TIMEOUT_CYC it clears both pend flags and the timer. Any popped byte resets the timer.
- Overflow: when overflow=1 is sampled, set err and clear ext_pend, brk_pend and skip_cnt. Popping continues. Held modifiers are kept.
- Simultaneous events: a byte decoded in the same cycle as a timeout expiry uses the pend flags from before the clear, so the byte wins. An overflow in the same cycle as DECODE is applied after the decode.
- Reset mid-sequence: a partial prefix is lost. No event is emitted for it.

Test Plan:
- FIFO bytes 1C, F0, 1C → 3 pops (nextdata_n low 3 single cycles); event 1: code=1C, break=0, repeat=0, count=1; event 2: code=1C, break=1; count stays 1.
- 1C,1C,1C,F0,1C → events 2 and 3 have repeat=1; count=1 at end; final event break=1.
- 12, 1C, F0,1C, F0,12 → shift=1 after first event, shift=1 during the 1C events, shift=0 after final event; count=2 (12 and 1C).
- E0,14 then E0,F0,14 → event ext=1, code=14, ctrl=1; then ext=1, break=1, ctrl=0. Then 58, F0,58, 58 → caps 0→1→1→0.
- E1,14,77,E1,F0,14,F0,77 → no key_valid, count unchanged. Then F0 alone with TIMEOUT_CYC=16 and FIFO empty for 20 cycles, then 1C → event break=0.
- Pulse overflow during E0 prefix, then 1C → err=1, event ext=0. Assert rst asynchronously mid-POP → nextdata_n=1 and all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// Turns raw PS/2 scan-code bytes from the receive FIFO into single key events.
// Tracks modifier state, flags typematic repeats and recovers from stale prefixes.
module ps2_key_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 1000000,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_ready,
   input  logic             overflow,
   output logic             nextdata_n,
   output logic             key_valid,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_break,
   output logic             key_repeat,
   output logic             shift,
   output logic             ctrl,
   output logic             caps,
   output logic [CNT_W-1:0] press_count,
   output logic             err
);

   localparam int unsigned TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int unsigned SKIP_W = 3;
   localparam int unsigned KEY_W  = 9;

   localparam logic [7:0] CODE_E0     = 8'hE0;
   localparam logic [7:0] CODE_E1     = 8'hE1;
   localparam logic [7:0] CODE_F0     = 8'hF0;
   localparam logic [7:0] CODE_LSHIFT = 8'h12;
   localparam logic [7:0] CODE_RSHIFT = 8'h59;
   localparam logic [7:0] CODE_CTRL   = 8'h14;
   localparam logic [7:0] CODE_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_POP    = 2'd1,
      S_SETTLE = 2'd2,
      S_DECODE = 2'd3
   } state_t;

   state_t             state;
   logic [7:0]         byte_r;
   logic               ext_pend;
   logic               brk_pend;
   logic [SKIP_W-1:0]  skip_cnt;
   logic [KEY_W-1:0]   last_make;
   logic               last_vld;
   logic [TMR_W-1:0]   timer;
   logic               shift_l;
   logic               shift_r;
   logic               ctrl_l;
   logic               ctrl_r;

   logic [KEY_W-1:0]   key_c;
   logic               emit_c;
   logic               match_c;
   logic               make_c;
   logic               new_make_c;
   logic               shift_l_c;
   logic               shift_r_c;
   logic               ctrl_l_c;
   logic               ctrl_r_c;

   // Classify the byte being decoded and compute the held-modifier update
   always_comb begin
      key_c      = {ext_pend, byte_r};
      emit_c     = (state == S_DECODE) && (skip_cnt == '0) &&
                   (byte_r != CODE_E1) && (byte_r != CODE_E0) && (byte_r != CODE_F0);
      match_c    = last_vld && (last_make == key_c);
      make_c     = !brk_pend;
      new_make_c = make_c && !match_c;
      shift_l_c  = shift_l;
      shift_r_c  = shift_r;
      ctrl_l_c   = ctrl_l;
      ctrl_r_c   = ctrl_r;
      if (emit_c) begin
         // E0 12 / E0 59 are fake shifts and deliberately fall through untouched
         if (!ext_pend) begin
            if (byte_r == CODE_LSHIFT) shift_l_c = make_c;
            if (byte_r == CODE_RSHIFT) shift_r_c = make_c;
            if (byte_r == CODE_CTRL)   ctrl_l_c  = make_c;
         end else if (byte_r == CODE_CTRL) begin
            ctrl_r_c = make_c;
         end
      end
   end

   // Pop handshake, prefix folding, event/modifier registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         byte_r      <= '0;
         ext_pend    <= 1'b0;
         brk_pend    <= 1'b0;
         skip_cnt    <= '0;
         last_make   <= '0;
         last_vld    <= 1'b0;
         timer       <= '0;
         shift_l     <= 1'b0;
         shift_r     <= 1'b0;
         ctrl_l      <= 1'b0;
         ctrl_r      <= 1'b0;
         nextdata_n  <= 1'b1;
         key_valid   <= 1'b0;
         key_code    <= '0;
         key_ext     <= 1'b0;
         key_break   <= 1'b0;
         key_repeat  <= 1'b0;
         shift       <= 1'b0;
         ctrl        <= 1'b0;
         caps        <= 1'b0;
         press_count <= '0;
         err         <= 1'b0;
      end else begin
         key_valid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (in_ready) begin
                  byte_r     <= in_data;
                  nextdata_n <= 1'b0;
                  state      <= S_POP;
               end
            end
            S_POP: begin
               nextdata_n <= 1'b1;
               state      <= S_SETTLE;
            end
            S_SETTLE: state <= S_DECODE;
            S_DECODE: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase

         // Stale-prefix timer; decode below overrides a coincident expiry
         if (state == S_IDLE && in_ready) begin
            timer <= '0;
         end else if ((ext_pend || brk_pend) && !in_ready) begin
            if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
               timer    <= '0;
               ext_pend <= 1'b0;
               brk_pend <= 1'b0;
            end else begin
               timer <= timer + TMR_W'(1);
            end
         end

         if (state == S_DECODE) begin
            if (skip_cnt != '0) begin
               skip_cnt <= skip_cnt - SKIP_W'(1);
            end else if (byte_r == CODE_E1) begin
               skip_cnt <= SKIP_W'(7);
            end else if (byte_r == CODE_E0) begin
               ext_pend <= 1'b1;
            end else if (byte_r == CODE_F0) begin
               brk_pend <= 1'b1;
            end else begin
               ext_pend <= 1'b0;
               brk_pend <= 1'b0;
            end
         end

         if (emit_c) begin
            key_valid  <= 1'b1;
            key_code   <= byte_r;
            key_ext    <= ext_pend;
            key_break  <= brk_pend;
            key_repeat <= make_c && match_c;
            if (new_make_c) begin
               last_make   <= key_c;
               last_vld    <= 1'b1;
               press_count <= press_count + CNT_W'(1);
               if (!ext_pend && byte_r == CODE_CAPS) caps <= !caps;
            end else if (!make_c && match_c) begin
               last_vld <= 1'b0;
            end
         end

         shift_l <= shift_l_c;
         shift_r <= shift_r_c;
         ctrl_l  <= ctrl_l_c;
         ctrl_r  <= ctrl_r_c;
         shift   <= shift_l_c || shift_r_c;
         ctrl    <= ctrl_l_c || ctrl_r_c;

         // Overflow drops any partial sequence; applied after a coincident decode
         if (overflow) begin
            err      <= 1'b1;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            skip_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: a small FIFO model feeds scan codes,
// events are logged at the falling edge and compared with hand-derived values.
module tb_ps2_key_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_ready;
   logic       overflow;
   logic       nextdata_n;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       key_repeat;
   logic       shift;
   logic       ctrl;
   logic       caps;
   logic [7:0] press_count;
   logic       err;

   ps2_key_sequencer #(.TIMEOUT_CYC(16), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_ready(in_ready),
      .overflow(overflow), .nextdata_n(nextdata_n), .key_valid(key_valid),
      .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
      .key_repeat(key_repeat), .shift(shift), .ctrl(ctrl), .caps(caps),
      .press_count(press_count), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // FIFO model: head visible while non-empty, advances on a low nextdata_n edge
   logic [7:0] fifo_mem [64];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign in_ready = (wr_ptr != rd_ptr);
   assign in_data  = fifo_mem[rd_ptr[5:0]];

   always @(posedge clk) begin
      if (!nextdata_n && (wr_ptr != rd_ptr)) rd_ptr <= rd_ptr + 1;
   end

   task automatic push(input logic [7:0] b);
      fifo_mem[wr_ptr[5:0]] = b;
      wr_ptr++;
   endtask

   // Event log: {ext,break,repeat,code}, {shift,ctrl,caps}, count
   logic [10:0] ev_key [64];
   logic [2:0]  ev_mod [64];
   logic [7:0]  ev_cnt [64];
   int ev_n  = 0;
   int pop_n = 0;
   bit prev_low = 1'b0;

   always @(negedge clk) begin
      if (!nextdata_n) begin
         check("pop_gap", 32'(prev_low), 32'd0);
         pop_n++;
      end
      prev_low = !nextdata_n;
      if (key_valid) begin
         ev_key[ev_n[5:0]] = {key_ext, key_break, key_repeat, key_code};
         ev_mod[ev_n[5:0]] = {shift, ctrl, caps};
         ev_cnt[ev_n[5:0]] = press_count;
         ev_n++;
      end
   end

   task automatic drain();
      int t = 0;
      while (rd_ptr != wr_ptr && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("drain_bound", 32'(t < 500), 32'd1);
      repeat (8) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_ev(input int idx, input logic [10:0] key, input logic [2:0] md,
                         input logic [7:0] cnt);
      check($sformatf("ev%0d_key", idx), 32'(ev_key[idx[5:0]]), 32'(key));
      check($sformatf("ev%0d_mod", idx), 32'(ev_mod[idx[5:0]]), 32'(md));
      check($sformatf("ev%0d_cnt", idx), 32'(ev_cnt[idx[5:0]]), 32'(cnt));
   endtask

   int be;
   int bp;

   initial begin
      rst      = 1'b1;
      overflow = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_outs", 32'({nextdata_n, key_valid, key_code, key_ext, key_break,
                             key_repeat, shift, ctrl, caps, press_count, err}),
            32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}));
      rst = 1'b0;
      @(negedge clk);

      // make then break of one key
      be = ev_n; bp = pop_n;
      push(8'h1C); push(8'hF0); push(8'h1C);
      drain();
      check("t1_pops", 32'(pop_n - bp), 32'd3);
      check("t1_nev", 32'(ev_n - be), 32'd2);
      chk_ev(be,     {3'b000, 8'h1C}, 3'b000, 8'd1);
      chk_ev(be + 1, {3'b010, 8'h1C}, 3'b000, 8'd1);

      // typematic repeats
      do_reset();
      be = ev_n;
      push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
      drain();
      check("t2_nev", 32'(ev_n - be), 32'd4);
      chk_ev(be,     {3'b000, 8'h1C}, 3'b000, 8'd1);
      chk_ev(be + 1, {3'b001, 8'h1C}, 3'b000, 8'd1);
      chk_ev(be + 2, {3'b001, 8'h1C}, 3'b000, 8'd1);
      chk_ev(be + 3, {3'b010, 8'h1C}, 3'b000, 8'd1);

      // shift held across another key
      do_reset();
      be = ev_n;
      push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
      drain();
      check("t3_nev", 32'(ev_n - be), 32'd4);
      chk_ev(be,     {3'b000, 8'h12}, 3'b100, 8'd1);
      chk_ev(be + 1, {3'b000, 8'h1C}, 3'b100, 8'd2);
      chk_ev(be + 2, {3'b010, 8'h1C}, 3'b100, 8'd2);
      chk_ev(be + 3, {3'b010, 8'h12}, 3'b000, 8'd2);

      // right ctrl, caps toggle, fake shift
      do_reset();
      be = ev_n;
      push(8'hE0); push(8'h14); push(8'hE0); push(8'hF0); push(8'h14);
      push(8'h58); push(8'hF0); push(8'h58); push(8'h58);
      push(8'hE0); push(8'h12);
      drain();
      check("t4_nev", 32'(ev_n - be), 32'd6);
      chk_ev(be,     {3'b100, 8'h14}, 3'b010, 8'd1);
      chk_ev(be + 1, {3'b110, 8'h14}, 3'b000, 8'd1);
      chk_ev(be + 2, {3'b000, 8'h58}, 3'b001, 8'd2);
      chk_ev(be + 3, {3'b010, 8'h58}, 3'b001, 8'd2);
      chk_ev(be + 4, {3'b000, 8'h58}, 3'b000, 8'd3);
      chk_ev(be + 5, {3'b100, 8'h12}, 3'b000, 8'd4);

      // Pause sequence swallowed, then stale F0 times out
      do_reset();
      be = ev_n; bp = pop_n;
      push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
      push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
      drain();
      check("t5_pops", 32'(pop_n - bp), 32'd8);
      check("t5_nev", 32'(ev_n - be), 32'd0);
      check("t5_cnt", 32'(press_count), 32'd0);
      push(8'hF0);
      drain();
      repeat (20) @(negedge clk);
      push(8'h1C);
      drain();
      check("t5_nev2", 32'(ev_n - be), 32'd1);
      chk_ev(be, {3'b000, 8'h1C}, 3'b000, 8'd1);

      // overflow during an E0 prefix
      do_reset();
      be = ev_n;
      check("t6_err0", 32'(err), 32'd0);
      push(8'hE0);
      drain();
      overflow = 1'b1;
      @(negedge clk);
      overflow = 1'b0;
      push(8'h1C);
      drain();
      check("t6_err1", 32'(err), 32'd1);
      check("t6_nev", 32'(ev_n - be), 32'd1);
      chk_ev(be, {3'b000, 8'h1C}, 3'b000, 8'd1);

      // asynchronous reset while the pop strobe is low
      begin
         int t = 0;
         push(8'h1C);
         while (nextdata_n && t < 50) begin
            @(negedge clk);
            t++;
         end
         check("t7_pop_seen", 32'(nextdata_n), 32'd0);
         #1 rst = 1'b1;
         #1;
         check("t7_async_rst", 32'({nextdata_n, key_valid, key_code, key_ext, key_break,
                                    key_repeat, shift, ctrl, caps, press_count, err}),
               32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}));
         @(negedge clk);
         rst = 1'b0;
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
